led_grant_sched: RTL
====================

Name: led_grant_sched

Overview:
- Round-robin scheduler that shares the single 3-to-8 active-low LED decoder between 8 requesters.
- Drives the decoder select (SEL -> decoder IN) and its active-low ENABLE, so the lit LED shows the current owner.
- Enforces a minimum dwell and a maximum hold per grant; also returns a one-hot grant to the requesters.

Parameters:
- DWELL, 4: minimum grant length in cycles; legal range 1..MAX_HOLD.
- MAX_HOLD, 16: maximum grant length in cycles before forced rotation; legal range DWELL..256.

Ports:
- CLK  input  1  clock; all state updates on its rising edge.
- RST_N  input  1  synchronous, active-low reset, sampled on the CLK rising edge.
- REQ  input  8  request per requester, level-sensitive, bit i = requester i.
- SEL  output  3  index of the granted requester; drives decoder IN.
- ENABLE  output  1  active-low decoder enable; 0 = a grant is active, 1 = no grant (all LEDs off).
- GNT  output  8  one-hot grant, all zero when idle; equals 1<<SEL while ENABLE=0.
- BUSY  output  1  1 while in GRANT state.

Behaviour:
- All outputs are registered; no combinational path from REQ to any output.
- Reset (RST_N=0 at an edge):
  - SEL=0, ENABLE=1, GNT=0, BUSY=0.
  - Dwell counter CNT=0; state=IDLE.
  - Priority pointer LAST=7, so the first search starts at requester 0.
  - Reset wins over every other event, including mid-grant; the grant is dropped at that edge.
- Arbitration function PICK(p): first i in the order p+1, p+2, ... (mod 8, wrapping 7->0) with REQ[i]=1.
- IDLE state:
  - If REQ != 0: at the next edge, state=GRANT, SEL=PICK(LAST), GNT=1<<SEL, ENABLE=0, BUSY=1, CNT=0.
  - Latency: REQ high in cycle n gives the grant visible in cycle n+1.
  - Otherwise hold IDLE.
- GRANT state (CNT = number of completed cycles of this grant, starting at 0):
  - Voluntary release: CNT >= DWELL-1 and REQ[SEL]=0.
  - Forced release: CNT == MAX_HOLD-1, regardless of REQ[SEL].
  - No release condition: CNT increments and SEL/GNT hold.
  - A grant therefore lasts at least DWELL cycles and at most MAX_HOLD cycles, even if the request drops after one cycle.
- At a release edge:
  - LAST is set to the current SEL.
  - If any REQ bit is 1 (the current bit included), grant PICK(SEL) directly at that edge, with CNT=0 and no idle cycle between grants.
  - If the only request left is the current owner (forced case), it is re-granted to itself, again with no gap.
  - If REQ=0, go to IDLE with ENABLE=1, GNT=0, BUSY=0; SEL keeps its last value.
- Requests that change during a grant have no effect until the release edge.
- CNT width is clog2(MAX_HOLD) bits; CNT never wraps.
- ENABLE=0 implies exactly one GNT bit set, and GNT[SEL]=1.

Test Plan:
1. Reset: drive REQ=8'hFF and hold RST_N=0 for 3 cycles -> SEL=0, ENABLE=1, GNT=8'h00, BUSY=0. After RST_N=1 -> first grant is SEL=0, GNT=8'h01, one cycle later.
2. Short request: REQ=8'h20 for 1 cycle then 0 (DWELL=4) -> SEL=5, GNT=8'h20, ENABLE=0 for exactly 4 cycles, then ENABLE=1, GNT=8'h00.
3. Voluntary release: REQ[3] held 10 cycles then dropped -> GNT=8'h08 for 10 cycles; ENABLE=1 from the first cycle after REQ[3] is seen low.
4. Full rotation: REQ=8'hFF held (MAX_HOLD=16) -> grants 0,1,...,7,0 are each exactly 16 cycles, ENABLE never returns to 1, GNT always one-hot.
5. Sole hog: only REQ[2] held for 40 cycles -> forced release at 16 and 32 re-grants SEL=2 with no gap; GNT=8'h04 continuous.
6. Pointer fairness with reset: grant 6 completes with REQ=8'h82 -> next SEL=7, then SEL=1. Then assert RST_N=0 mid-grant -> GNT=0 and ENABLE=1 at that edge; LAST=7, so the next grant goes to requester 1 before 7.

Source files
------------

// File: rtl/led_grant_sched_if.sv
// led_grant_sched_if: requester-side bundle of the LED decoder scheduler.
// req    : per-requester level request (requester drives)
// sel    : granted index, feeds the 3-to-8 decoder IN
// enable : active-low decoder enable, 0 while a grant is active
// gnt    : one-hot grant back to the requesters, zero when idle
// busy   : high while a grant is active
interface led_grant_sched_if;
  logic [7:0] req;
  logic [2:0] sel;
  logic       enable;
  logic [7:0] gnt;
  logic       busy;
  modport master (output req, input sel, enable, gnt, busy);
  modport slave  (input req, output sel, enable, gnt, busy);
endinterface

// File: rtl/led_grant_sched.sv
// led_grant_sched: round-robin owner of the shared LED decoder with min dwell / max hold.
// clk   : rising-edge clock
// rst_n : synchronous active-low reset
// bus   : slave side of led_grant_sched_if (req in; sel/enable/gnt/busy registered out)
module led_grant_sched #(
  parameter int DWELL    = 4,
  parameter int MAX_HOLD = 16
) (
  input logic         clk,
  input logic         rst_n,
  led_grant_sched_if.slave bus
);
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] DW_M1 = CW'(DWELL - 1);
  localparam logic [CW-1:0] MH_M1 = CW'(MAX_HOLD - 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t        state, state_n;
  logic [2:0]    sel_n, last, last_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          rel;
  // Nearest requester after p, wrapping; i = 8 maps back to p itself so a
  // lone owner is re-granted on a forced release.
  function automatic logic [2:0] pick(input logic [2:0] p, input logic [7:0] r);
    logic [2:0] idx;
    pick = p;
    for (int i = 8; i >= 1; i--) begin
      idx = p + 3'(i);
      if (r[idx]) pick = idx;
    end
  endfunction
  always_comb begin
    state_n = state;
    sel_n   = bus.sel;
    last_n  = last;
    cnt_n   = cnt;
    rel     = (cnt == MH_M1) || (cnt >= DW_M1 && !bus.req[bus.sel]);
    if (state == IDLE) begin
      if (|bus.req) begin
        state_n = GRANT;
        sel_n   = pick(last, bus.req);
        cnt_n   = '0;
      end
    end else if (rel) begin
      last_n = bus.sel;
      cnt_n  = '0;
      if (|bus.req) sel_n = pick(bus.sel, bus.req);
      else state_n = IDLE;
    end else begin
      cnt_n = cnt + 1'b1;
    end
  end
  // Outputs are registered from the next-state values so the decoder sees the
  // new owner in the same cycle the state changes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last       <= 3'd7;
      bus.sel    <= 3'd0;
      bus.enable <= 1'b1;
      bus.gnt    <= 8'h00;
      bus.busy   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      last       <= last_n;
      bus.sel    <= sel_n;
      bus.enable <= state_n != GRANT;
      bus.gnt    <= (state_n == GRANT) ? (8'h01 << sel_n) : 8'h00;
      bus.busy   <= state_n == GRANT;
    end
  end
endmodule
